touch_sample_sched: RTL and testbench
=====================================

// Module: touch_sample_sched
// PURPOSE
//  Scan scheduler for the touch ADC. Sits above the SPI transfer controller:
//  while the pen is down it issues periodic X/Y conversion commands and averages
//  2**N_AVG_LOG2 samples per axis. It publishes one averaged coordinate pair
//  with a valid pulse and aborts cleanly if the transfer controller stalls.
// PARAMETERS
//  N_AVG_LOG2  2      log2 of samples averaged per axis (1..4)
//  PERIOD      50000  CLK cycles between scan-start ticks (>=2)
//  TIMEOUT     4096   max CLK cycles from XFER_ACK to XFER_DONE
//  CMD_X       8'hD0  ADC control byte for the X channel
//  CMD_Y       8'h90  ADC control byte for the Y channel
// PORTS
//  CLK           in   1   system clock
//  RST_n         in   1   reset, asynchronous, active-low
//  ADC_PENIRQ_n  in   1   pen interrupt from ADC, async, low = touched
//  XFER_REQ      out  1   request one conversion transfer
//  XFER_CMD      out  8   control byte for the requested transfer
//  XFER_ACK      in   1   controller accepted the request (1-cycle pulse)
//  XFER_DONE     in   1   transfer finished, XFER_DATA valid (1-cycle pulse)
//  XFER_DATA     in   12  conversion result
//  X_OUT         out  12  averaged X, held until the next publish
//  Y_OUT         out  12  averaged Y, held until the next publish
//  XY_VALID      out  1   1-cycle pulse when X_OUT/Y_OUT update
//  PEN_DOWN      out  1   synchronised, inverted ADC_PENIRQ_n
//  BUSY          out  1   high from scan start until return to IDLE
//  ERR_TIMEOUT   out  1   1-cycle pulse on transfer timeout
// BEHAVIOUR
//  - Reset: all outputs 0, XFER_CMD=8'h00, counters/accumulators 0, state IDLE.
//  - ADC_PENIRQ_n passes through a 2-FF synchroniser. PEN_DOWN = ~sync output,
//    so PEN_DOWN lags the pin by 2 cycles.
//  - Tick counter: free-running 0..PERIOD-1. TICK=1 for one cycle at PERIOD-1.
//    It counts in every state and is never cleared except by reset.
//  - States: IDLE, REQ, WAIT_DONE, ACCUM, PUBLISH.
//  - IDLE: on TICK & PEN_DOWN, go to REQ with axis=X, sample count=0 and
//    accX=accY=0. A TICK seen in any non-IDLE state is dropped, not queued.
//    The pen is sampled only in IDLE, because PENIRQ is unreliable during
//    conversions. A started scan always runs to PUBLISH or to a timeout.
//  - REQ: XFER_REQ=1. XFER_CMD=CMD_X or CMD_Y per axis, stable while XFER_REQ=1.
//    Hold until XFER_ACK=1. On the same edge drop XFER_REQ and go to WAIT_DONE
//    with the timeout counter cleared. ACK is never awaited by a timeout.
//  - WAIT_DONE: on XFER_DONE, capture XFER_DATA and go to ACCUM. If TIMEOUT
//    cycles elapse first, pulse ERR_TIMEOUT, go to IDLE and discard the
//    accumulators. X_OUT/Y_OUT keep their previous values.
//  - ACCUM (1 cycle): add the captured data to accX or accY. Accumulator width
//    is 12+N_AVG_LOG2, so overflow cannot occur. When the count reaches
//    2**N_AVG_LOG2-1: if axis=X, set axis=Y, clear the count and go to REQ;
//    if axis=Y, go to PUBLISH. Otherwise increment the count and go to REQ.
//  - PUBLISH (1 cycle): X_OUT=accX>>N_AVG_LOG2 and Y_OUT=accY>>N_AVG_LOG2
//    (truncating). Pulse XY_VALID and return to IDLE.
//  - BUSY=1 in every state except IDLE.
//  - XFER_DONE/XFER_ACK arriving outside WAIT_DONE/REQ are ignored.
//  - Asynchronous reset mid-scan: XFER_REQ drops immediately, nothing is
//    published, and the scan restarts only on a later TICK.
// TESTING
//  1 Reset, PENIRQ_n=1 for 3*PERIOD -> XFER_REQ never asserted,
//    BUSY=0, XY_VALID=0.
//  2 PENIRQ_n=0, model returns X=100,102,104,106 and Y=200x4 -> 8 requests
//    (4x8'hD0 then 4x8'h90), one XY_VALID with X_OUT=103, Y_OUT=200.
//  3 Model delays ACK 10 cycles -> XFER_REQ/XFER_CMD held stable for all
//    10 cycles, result unchanged.
//  4 Model never sends DONE on 3rd X transfer -> ERR_TIMEOUT pulse TIMEOUT
//    cycles after ACK, no XY_VALID, outputs keep prior pair, next TICK rescans.
//  5 Release pen mid-scan -> scan completes with XY_VALID, next TICK
//    starts no scan.
//  6 Assert RST_n=0 during WAIT_DONE -> XFER_REQ/BUSY/X_OUT=0 immediately;
//    a spurious XFER_DONE after release is ignored.

Source files
------------

// File: rtl/touch_sample_sched.sv
// touch_sample_sched: pen-down periodic X/Y scan scheduler with 2**N_AVG_LOG2 averaging
// Ports:
//   CLK, RST_n (async, active-low)  clock and reset
//   ADC_PENIRQ_n                    async pen interrupt, low = touched
//   XFER_REQ/XFER_CMD               conversion request and its control byte
//   XFER_ACK/XFER_DONE/XFER_DATA    transfer controller handshake and result
//   X_OUT/Y_OUT/XY_VALID            averaged coordinate pair and update pulse
//   PEN_DOWN, BUSY, ERR_TIMEOUT     status outputs
module touch_sample_sched #(
    parameter int         N_AVG_LOG2 = 2,
    parameter int         PERIOD     = 50000,
    parameter int         TIMEOUT    = 4096,
    parameter logic [7:0] CMD_X      = 8'hD0,
    parameter logic [7:0] CMD_Y      = 8'h90
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        ADC_PENIRQ_n,
    output logic        XFER_REQ,
    output logic [7:0]  XFER_CMD,
    input  logic        XFER_ACK,
    input  logic        XFER_DONE,
    input  logic [11:0] XFER_DATA,
    output logic [11:0] X_OUT,
    output logic [11:0] Y_OUT,
    output logic        XY_VALID,
    output logic        PEN_DOWN,
    output logic        BUSY,
    output logic        ERR_TIMEOUT
);
    localparam int TW = $clog2(PERIOD);
    localparam int OW = $clog2(TIMEOUT + 1);
    localparam int AW = 12 + N_AVG_LOG2;
    typedef enum logic [2:0] {IDLE, REQ, WAIT_DONE, ACCUM, PUBLISH} state_t;
    state_t                st, nxt;
    logic [1:0]            pen_s;
    logic [TW-1:0]         tick_cnt;
    logic [OW-1:0]         to_cnt;
    logic [N_AVG_LOG2-1:0] cnt;
    logic                  axis;
    logic [11:0]           data_q;
    logic [AW-1:0]         acc_x, acc_y;
    logic                  tick, to_hit, last, start;
    assign tick     = tick_cnt == TW'(PERIOD - 1);
    assign to_hit   = to_cnt == OW'(TIMEOUT - 1);
    assign last     = &cnt;
    assign PEN_DOWN = ~pen_s[1];
    assign start    = st == IDLE && tick && PEN_DOWN;
    assign XFER_REQ = st == REQ;
    assign XFER_CMD = XFER_REQ ? (axis ? CMD_Y : CMD_X) : 8'h00;
    assign BUSY     = st != IDLE;
    always_ff @(posedge CLK or negedge RST_n)
        if (!RST_n) st <= IDLE;
        else        st <= nxt;
    always_comb begin
        nxt = st;
        case (st)
            IDLE:      nxt = start ? REQ : IDLE;
            REQ:       nxt = XFER_ACK ? WAIT_DONE : REQ;
            WAIT_DONE: nxt = XFER_DONE ? ACCUM : (to_hit ? IDLE : WAIT_DONE);
            ACCUM:     nxt = (last && axis) ? PUBLISH : REQ;
            PUBLISH:   nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            pen_s       <= 2'b11;
            tick_cnt    <= '0;
            to_cnt      <= '0;
            cnt         <= '0;
            axis        <= 1'b0;
            data_q      <= '0;
            acc_x       <= '0;
            acc_y       <= '0;
            X_OUT       <= '0;
            Y_OUT       <= '0;
            XY_VALID    <= 1'b0;
            ERR_TIMEOUT <= 1'b0;
        end else begin
            pen_s       <= {pen_s[0], ADC_PENIRQ_n};
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            XY_VALID    <= st == PUBLISH;
            ERR_TIMEOUT <= st == WAIT_DONE && !XFER_DONE && to_hit;
            if (start) begin
                axis  <= 1'b0;
                cnt   <= '0;
                acc_x <= '0;
                acc_y <= '0;
            end
            if (st == REQ) to_cnt <= '0;
            if (st == WAIT_DONE) begin
                to_cnt <= to_cnt + 1'b1;
                if (XFER_DONE) data_q <= XFER_DATA;
            end
            if (st == ACCUM) begin
                if (axis) acc_y <= acc_y + AW'(data_q);
                else      acc_x <= acc_x + AW'(data_q);
                // count wraps to zero after the last sample of an axis
                cnt <= cnt + 1'b1;
                if (last && !axis) axis <= 1'b1;
            end
            if (st == PUBLISH) begin
                X_OUT <= 12'(acc_x >> N_AVG_LOG2);
                Y_OUT <= 12'(acc_y >> N_AVG_LOG2);
            end
        end
    end
endmodule

// File: tb/tb_touch_sample_sched.sv
// tb_touch_sample_sched: directed bench for the touch scan scheduler
module tb_touch_sample_sched;
    localparam int PERIOD  = 200;
    localparam int TIMEOUT = 64;
    logic        CLK = 1'b0, RST_n = 1'b1, ADC_PENIRQ_n = 1'b1;
    logic        XFER_REQ, XFER_ACK, XFER_DONE;
    logic [7:0]  XFER_CMD;
    logic [11:0] XFER_DATA, X_OUT, Y_OUT;
    logic        XY_VALID, PEN_DOWN, BUSY, ERR_TIMEOUT;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_req = 0, base = 0, drop_idx = -1, ack_dly = 0, done_dly = 2;
    int stable_bad = 0, t_ack = 0, kick = 0;
    logic        mute = 1'b0;
    logic [7:0]  cmd_log [0:255];
    logic [11:0] vals [0:7];
    touch_sample_sched #(.N_AVG_LOG2(2), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_n(RST_n), .ADC_PENIRQ_n(ADC_PENIRQ_n),
        .XFER_REQ(XFER_REQ), .XFER_CMD(XFER_CMD), .XFER_ACK(XFER_ACK),
        .XFER_DONE(XFER_DONE), .XFER_DATA(XFER_DATA), .X_OUT(X_OUT), .Y_OUT(Y_OUT),
        .XY_VALID(XY_VALID), .PEN_DOWN(PEN_DOWN), .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT)
    );
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic wait_valid(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 3 * PERIOD && !got; i++) begin
            @(negedge CLK);
            if (XY_VALID) got = 1;
        end
        check(tag, 32'(got), 1);
    endtask
    // transfer controller model: acks after ack_dly cycles, answers from vals[]
    initial begin : model
        int idx, kseen;
        logic [7:0] c;
        XFER_ACK = 0; XFER_DONE = 0; XFER_DATA = 0; kseen = 0;
        forever begin
            @(negedge CLK);
            if (kick != kseen) begin
                kseen = kick;
                XFER_DATA = 12'hABC; XFER_DONE = 1;
                @(negedge CLK);
                XFER_DONE = 0;
            end else if (XFER_REQ) begin
                c = XFER_CMD;
                idx = n_req - base;
                cmd_log[n_req[7:0]] = c;
                n_req++;
                repeat (ack_dly) begin
                    @(negedge CLK);
                    if (XFER_REQ !== 1'b1 || XFER_CMD !== c) stable_bad++;
                end
                XFER_ACK = 1; t_ack = cyc;
                @(negedge CLK);
                XFER_ACK = 0;
                if (!mute && idx != drop_idx) begin
                    repeat (done_dly) @(negedge CLK);
                    XFER_DATA = vals[idx[2:0]]; XFER_DONE = 1;
                    @(negedge CLK);
                    XFER_DONE = 0;
                end
            end
        end
    end
    initial begin : main
        int busy_seen, valid_seen, err_cyc, base2;
        bit got;
        vals = '{100, 102, 104, 106, 200, 200, 200, 200};
        #1 RST_n = 0;
        #1;
        check("rst_req", 32'(XFER_REQ), 0);
        check("rst_cmd", 32'(XFER_CMD), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_valid", 32'(XY_VALID), 0);
        check("rst_x", 32'(X_OUT), 0);
        check("rst_pen", 32'(PEN_DOWN), 0);
        check("rst_err", 32'(ERR_TIMEOUT), 0);
        repeat (3) @(negedge CLK);
        RST_n = 1;
        busy_seen = 0; valid_seen = 0;
        repeat (3 * PERIOD) begin
            @(negedge CLK);
            if (BUSY) busy_seen++;
            if (XY_VALID) valid_seen++;
        end
        check("idle_req", 32'(n_req), 0);
        check("idle_busy", 32'(busy_seen), 0);
        check("idle_valid", 32'(valid_seen), 0);
        base = n_req;
        ADC_PENIRQ_n = 0;
        @(negedge CLK);
        check("pen_lag1", 32'(PEN_DOWN), 0);
        @(negedge CLK);
        check("pen_lag2", 32'(PEN_DOWN), 1);
        wait_valid("scan_valid");
        check("scan_x", 32'(X_OUT), 103);
        check("scan_y", 32'(Y_OUT), 200);
        check("scan_nreq", 32'(n_req - base), 8);
        for (int i = 0; i < 8; i++) check("scan_cmd", 32'(cmd_log[base + i]), i < 4 ? 32'hD0 : 32'h90);
        @(negedge CLK);
        check("valid_pulse", 32'(XY_VALID), 0);
        ADC_PENIRQ_n = 1;
        ack_dly = 10; stable_bad = 0; base = n_req;
        ADC_PENIRQ_n = 0;
        wait_valid("slow_valid");
        check("slow_stable", 32'(stable_bad), 0);
        check("slow_x", 32'(X_OUT), 103);
        check("slow_y", 32'(Y_OUT), 200);
        check("slow_nreq", 32'(n_req - base), 8);
        ADC_PENIRQ_n = 1;
        ack_dly = 0; base = n_req; drop_idx = 2;
        ADC_PENIRQ_n = 0;
        got = 0; valid_seen = 0; err_cyc = 0;
        for (int i = 0; i < 3 * PERIOD && !got; i++) begin
            @(negedge CLK);
            if (XY_VALID) valid_seen++;
            if (ERR_TIMEOUT) begin got = 1; err_cyc = cyc; end
        end
        check("to_seen", 32'(got), 1);
        // ACK is taken at the edge after t_ack; ERR rises TIMEOUT edges later
        check("to_delay", 32'(err_cyc - t_ack), TIMEOUT + 1);
        check("to_novalid", 32'(valid_seen), 0);
        check("to_nreq", 32'(n_req - base), 3);
        check("to_keep_x", 32'(X_OUT), 103);
        check("to_keep_y", 32'(Y_OUT), 200);
        @(negedge CLK);
        check("to_pulse", 32'(ERR_TIMEOUT), 0);
        check("to_idle", 32'(BUSY), 0);
        vals = '{10, 11, 12, 13, 4095, 4095, 4095, 4095};
        drop_idx = -1; base = n_req;
        wait_valid("rescan_valid");
        check("rescan_x", 32'(X_OUT), 11);
        check("rescan_y", 32'(Y_OUT), 4095);
        ADC_PENIRQ_n = 1;
        vals = '{1, 2, 3, 4, 0, 0, 0, 7};
        base = n_req;
        ADC_PENIRQ_n = 0;
        got = 0;
        for (int i = 0; i < 3 * PERIOD && !got; i++) begin
            @(negedge CLK);
            if (BUSY) got = 1;
        end
        check("rel_start", 32'(got), 1);
        repeat (5) @(negedge CLK);
        ADC_PENIRQ_n = 1;
        wait_valid("rel_valid");
        check("rel_x", 32'(X_OUT), 2);
        check("rel_y", 32'(Y_OUT), 1);
        check("rel_nreq", 32'(n_req - base), 8);
        base2 = n_req; busy_seen = 0;
        repeat (PERIOD + 20) begin
            @(negedge CLK);
            if (BUSY) busy_seen++;
        end
        check("rel_noscan_req", 32'(n_req - base2), 0);
        check("rel_noscan_busy", 32'(busy_seen), 0);
        vals = '{5, 5, 5, 5, 9, 9, 9, 9};
        mute = 1; base = n_req;
        ADC_PENIRQ_n = 0;
        got = 0;
        for (int i = 0; i < 3 * PERIOD && !got; i++) begin
            @(negedge CLK);
            if (n_req - base >= 1 && !XFER_REQ && BUSY) got = 1;
        end
        check("ar_wait", 32'(got), 1);
        repeat (3) @(negedge CLK);
        #2 RST_n = 0;
        #1;
        check("ar_req", 32'(XFER_REQ), 0);
        check("ar_busy", 32'(BUSY), 0);
        check("ar_x", 32'(X_OUT), 0);
        check("ar_y", 32'(Y_OUT), 0);
        @(negedge CLK);
        RST_n = 1;
        kick++;
        busy_seen = 0; valid_seen = 0;
        repeat (30) begin
            @(negedge CLK);
            if (BUSY) busy_seen++;
            if (XY_VALID) valid_seen++;
        end
        check("ar_spur_busy", 32'(busy_seen), 0);
        check("ar_spur_valid", 32'(valid_seen), 0);
        check("ar_spur_x", 32'(X_OUT), 0);
        mute = 0; base = n_req;
        wait_valid("ar_rescan_valid");
        check("ar_rescan_x", 32'(X_OUT), 5);
        check("ar_rescan_y", 32'(Y_OUT), 9);
        ADC_PENIRQ_n = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
